usb_rx_packet: RTL and testbench

//  Packet decoder directly downstream of the ULPI link block. Consumes the received-byte stream
//  (RX_DATA/RX_STRB/RX_END/RX_FAIL), validates the PID, and decodes token and handshake packets.

---
 rtl/usb_pkg.sv | 84 ++++++++
 rtl/usb_crc16_byte.sv | 26 ++
 rtl/usb_rx_packet.sv | 349 ++++++++++++++++++++++++++++++++++
 tb/tb_usb_rx_packet.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared definitions for the USB receive packet decoder: PID values,
// packet classification, error codes, CRC constants and the CRC5 helper.
package usb_pkg;

  // PID[3:0] values
  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_SOF   = 4'h5;
  localparam logic [3:0] PID_SETUP = 4'hD;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_DATA2 = 4'h7;
  localparam logic [3:0] PID_MDATA = 4'hF;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;
  localparam logic [3:0] PID_NYET  = 4'h6;

  // ERR_CODE values
  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_PID   = 3'd1;
  localparam logic [2:0] ERR_CRC5  = 3'd2;
  localparam logic [2:0] ERR_CRC16 = 3'd3;
  localparam logic [2:0] ERR_LEN   = 3'd4;
  localparam logic [2:0] ERR_ABORT = 3'd5;
  localparam logic [2:0] ERR_SHORT = 3'd6;

  // CRC constants (register shifts left, data enters LSB-first)
  localparam logic [4:0]  CRC5_POLY      = 5'h05;
  localparam logic [4:0]  CRC5_INIT      = 5'h1F;
  localparam logic [4:0]  CRC5_RESIDUAL  = 5'h0C;
  localparam logic [15:0] CRC16_POLY     = 16'h8005;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

  typedef enum logic [1:0] {
    PT_TOKEN = 2'd0,
    PT_DATA  = 2'd1,
    PT_HSK   = 2'd2,
    PT_OTHER = 2'd3
  } pkt_type_t;

  // The PID byte is consumed directly in IDLE, so there is no separate PID state.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TOK1    = 3'd1,
    ST_TOK2    = 3'd2,
    ST_TEND    = 3'd3,
    ST_HSK     = 3'd4,
    ST_DATA    = 3'd5,
    ST_DISCARD = 3'd6
  } rx_state_t;

  // Upper nibble must be the complement of the lower nibble.
  function automatic logic pid_ok(input logic [7:0] pid_byte);
    return (pid_byte[7:4] == ~pid_byte[3:0]);
  endfunction

  function automatic pkt_type_t pid_type(input logic [3:0] pid);
    pkt_type_t t;
    case (pid)
      PID_OUT, PID_IN, PID_SOF, PID_SETUP:         t = PT_TOKEN;
      PID_DATA0, PID_DATA1, PID_DATA2, PID_MDATA: t = PT_DATA;
      PID_ACK, PID_NAK, PID_STALL, PID_NYET:      t = PT_HSK;
      default:                                    t = PT_OTHER;
    endcase
    return t;
  endfunction

  // Byte-wide CRC5 update, bit 0 of the byte first.
  function automatic logic [4:0] crc5_byte(input logic [4:0] crc_in, input logic [7:0] data);
    logic [4:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[4] ^ data[i]) begin
        c = {c[3:0], 1'b0} ^ CRC5_POLY;
      end else begin
        c = {c[3:0], 1'b0};
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/usb_crc16_byte.sv
// Byte-parallel CRC16 update: eight LSB-first serial steps unrolled.
module usb_crc16_byte
  import usb_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  logic [15:0] w_crc;

  // Shift the byte through the CRC register, bit 0 first.
  always_comb begin
    w_crc = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (w_crc[15] ^ data[i]) begin
        w_crc = {w_crc[14:0], 1'b0} ^ CRC16_POLY;
      end else begin
        w_crc = {w_crc[14:0], 1'b0};
      end
    end
  end

  assign crc_out = w_crc;

endmodule

// File: rtl/usb_rx_packet.sv
// USB receive packet decoder: PID validation, token/handshake decode,
// CRC5/CRC16 checking and data payload forwarding with CRC bytes stripped.
module usb_rx_packet
  import usb_pkg::*;
#(
  parameter int MAX_PAYLOAD = 1023,
  parameter int LEN_W       = 11
) (
  input  logic             CLK_60M,
  input  logic             NRST_A_USB,
  input  logic [7:0]       RX_DATA,
  input  logic             RX_STRB,
  input  logic             RX_END,
  input  logic             RX_FAIL,
  output logic [3:0]       PKT_PID,
  output logic [6:0]       PKT_ADDR,
  output logic [3:0]       PKT_ENDP,
  output logic [10:0]      PKT_FRAME,
  output logic             TOKEN_VALID,
  output logic             HSK_VALID,
  output logic [7:0]       DATA_OUT,
  output logic             DATA_STRB,
  output logic             DATA_END,
  output logic [LEN_W-1:0] DATA_LEN,
  output logic             PKT_ERR,
  output logic [2:0]       ERR_CODE
);

  // Bytes after the PID a data packet may carry: payload plus two CRC bytes.
  localparam logic [LEN_W-1:0] MAX_BYTES = LEN_W'(MAX_PAYLOAD + 2);

  // FSM
  rx_state_t r_state;
  rx_state_t w_state_nxt;
  rx_state_t w_mid_state;

  // Datapath state
  logic [15:0]      r_tok;
  logic [4:0]       r_crc5;
  logic [15:0]      r_crc16;
  logic [LEN_W-1:0] r_cnt;
  logic [7:0]       r_d0;
  logic [7:0]       r_d1;
  logic [15:0]      w_tok_nxt;
  logic [4:0]       w_crc5_nxt;
  logic [15:0]      w_crc16_nxt;
  logic [15:0]      w_crc16_upd;
  logic [LEN_W-1:0] w_cnt_nxt;
  logic [7:0]       w_d0_nxt;
  logic [7:0]       w_d1_nxt;
  logic             w_emit;

  // Event qualification
  logic w_byte;
  logic w_data_full;
  logic w_byte_err;
  logic [2:0] w_byte_code;
  logic w_end_err;
  logic [2:0] w_end_code;
  logic w_abort;
  logic w_tok_done;
  logic w_hsk_done;
  logic w_data_done;

  // Output registers and their next values
  logic [3:0]       r_pkt_pid,   w_pkt_pid_nxt;
  logic [6:0]       r_pkt_addr,  w_pkt_addr_nxt;
  logic [3:0]       r_pkt_endp,  w_pkt_endp_nxt;
  logic [10:0]      r_pkt_frame, w_pkt_frame_nxt;
  logic             r_tok_valid, w_tok_valid_nxt;
  logic             r_hsk_valid, w_hsk_valid_nxt;
  logic [7:0]       r_data_out,  w_data_out_nxt;
  logic             r_data_strb, w_data_strb_nxt;
  logic             r_data_end,  w_data_end_nxt;
  logic [LEN_W-1:0] r_data_len,  w_data_len_nxt;
  logic             r_pkt_err,   w_pkt_err_nxt;
  logic [2:0]       r_err_code,  w_err_code_nxt;

  // RX_FAIL outranks the byte strobe; a byte seen with RX_FAIL is dropped.
  assign w_byte      = RX_STRB & ~RX_FAIL;
  assign w_data_full = (r_cnt == MAX_BYTES);

  usb_crc16_byte u_crc16 (
    .crc_in  (r_crc16),
    .data    (RX_DATA),
    .crc_out (w_crc16_upd)
  );

  // FSM state register.
  always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
    if (!NRST_A_USB) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: apply this cycle's byte first, then any end or abort on the resulting state.
  always_comb begin
    w_mid_state = r_state;
    w_byte_err  = 1'b0;
    w_byte_code = ERR_NONE;
    if (w_byte) begin
      case (r_state)
        ST_IDLE: begin
          if (!pid_ok(RX_DATA)) begin
            w_mid_state = ST_DISCARD;
            w_byte_err  = 1'b1;
            w_byte_code = ERR_PID;
          end else begin
            case (pid_type(RX_DATA[3:0]))
              PT_TOKEN: w_mid_state = ST_TOK1;
              PT_DATA:  w_mid_state = ST_DATA;
              PT_HSK:   w_mid_state = ST_HSK;
              default: begin
                w_mid_state = ST_DISCARD;
                w_byte_err  = 1'b1;
                w_byte_code = ERR_LEN;
              end
            endcase
          end
        end
        ST_TOK1: w_mid_state = ST_TOK2;
        ST_TOK2: w_mid_state = ST_TEND;
        ST_TEND, ST_HSK: begin
          w_mid_state = ST_DISCARD;
          w_byte_err  = 1'b1;
          w_byte_code = ERR_LEN;
        end
        ST_DATA: begin
          if (w_data_full) begin
            w_mid_state = ST_DISCARD;
            w_byte_err  = 1'b1;
            w_byte_code = ERR_LEN;
          end else begin
            w_mid_state = ST_DATA;
          end
        end
        ST_DISCARD: w_mid_state = ST_DISCARD;
        default:    w_mid_state = ST_IDLE;
      endcase
    end else begin
      w_mid_state = r_state;
    end

    w_state_nxt = w_mid_state;
    w_end_err   = 1'b0;
    w_end_code  = ERR_NONE;
    w_tok_done  = 1'b0;
    w_hsk_done  = 1'b0;
    w_data_done = 1'b0;
    w_abort     = 1'b0;
    if (RX_FAIL) begin
      // DISCARD has already reported its error, IDLE has nothing to abort.
      w_abort     = (r_state != ST_IDLE) && (r_state != ST_DISCARD);
      w_state_nxt = ST_IDLE;
    end else if (RX_END) begin
      case (w_mid_state)
        ST_IDLE: w_state_nxt = ST_IDLE;
        ST_TOK1, ST_TOK2: begin
          w_end_err   = 1'b1;
          w_end_code  = ERR_SHORT;
          w_state_nxt = ST_IDLE;
        end
        ST_TEND: begin
          if (w_crc5_nxt == CRC5_RESIDUAL) begin
            w_tok_done = 1'b1;
          end else begin
            w_end_err  = 1'b1;
            w_end_code = ERR_CRC5;
          end
          w_state_nxt = ST_IDLE;
        end
        ST_HSK: begin
          w_hsk_done  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
        ST_DATA: begin
          if (w_cnt_nxt < LEN_W'(2)) begin
            w_end_err  = 1'b1;
            w_end_code = ERR_SHORT;
          end else if (w_crc16_nxt == CRC16_RESIDUAL) begin
            w_data_done = 1'b1;
          end else begin
            w_end_err  = 1'b1;
            w_end_code = ERR_CRC16;
          end
          w_state_nxt = ST_IDLE;
        end
        ST_DISCARD: w_state_nxt = ST_IDLE;
        default:    w_state_nxt = ST_IDLE;
      endcase
    end else begin
      w_state_nxt = w_mid_state;
    end
  end

  // Datapath next values: token capture, CRC accumulation and the 2-byte delay line.
  always_comb begin
    w_tok_nxt   = r_tok;
    w_crc5_nxt  = r_crc5;
    w_crc16_nxt = r_crc16;
    w_cnt_nxt   = r_cnt;
    w_d0_nxt    = r_d0;
    w_d1_nxt    = r_d1;
    w_emit      = 1'b0;
    if (w_byte) begin
      case (r_state)
        ST_IDLE: begin
          w_crc5_nxt  = CRC5_INIT;
          w_crc16_nxt = CRC16_INIT;
          w_cnt_nxt   = '0;
        end
        ST_TOK1: begin
          w_tok_nxt[7:0] = RX_DATA;
          w_crc5_nxt     = crc5_byte(r_crc5, RX_DATA);
        end
        ST_TOK2: begin
          w_tok_nxt[15:8] = RX_DATA;
          w_crc5_nxt      = crc5_byte(r_crc5, RX_DATA);
        end
        ST_DATA: begin
          if (!w_data_full) begin
            w_crc16_nxt = w_crc16_upd;
            w_cnt_nxt   = r_cnt + LEN_W'(1);
            w_d0_nxt    = r_d1;
            w_d1_nxt    = RX_DATA;
            // The newest two bytes may be the CRC, so only older bytes are released.
            w_emit      = (r_cnt >= LEN_W'(2));
          end else begin
            w_emit = 1'b0;
          end
        end
        default: w_emit = 1'b0;
      endcase
    end else begin
      w_emit = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
    if (!NRST_A_USB) begin
      r_tok   <= 16'h0000;
      r_crc5  <= 5'h00;
      r_crc16 <= 16'h0000;
      r_cnt   <= '0;
      r_d0    <= 8'h00;
      r_d1    <= 8'h00;
    end else begin
      r_tok   <= w_tok_nxt;
      r_crc5  <= w_crc5_nxt;
      r_crc16 <= w_crc16_nxt;
      r_cnt   <= w_cnt_nxt;
      r_d0    <= w_d0_nxt;
      r_d1    <= w_d1_nxt;
    end
  end

  // Output next values derived from the events decoded this cycle.
  always_comb begin
    w_tok_valid_nxt = w_tok_done;
    w_hsk_valid_nxt = w_hsk_done;
    w_data_strb_nxt = w_emit;
    w_data_end_nxt  = w_data_done;
    w_pkt_err_nxt   = w_byte_err | w_end_err | w_abort;
    if (w_byte_err) begin
      w_err_code_nxt = w_byte_code;
    end else if (w_end_err) begin
      w_err_code_nxt = w_end_code;
    end else if (w_abort) begin
      w_err_code_nxt = ERR_ABORT;
    end else begin
      w_err_code_nxt = ERR_NONE;
    end

    if (w_byte && (r_state == ST_IDLE)) begin
      w_pkt_pid_nxt  = RX_DATA[3:0];
      w_data_len_nxt = '0;
    end else if (w_emit) begin
      w_pkt_pid_nxt  = r_pkt_pid;
      w_data_len_nxt = r_data_len + LEN_W'(1);
    end else begin
      w_pkt_pid_nxt  = r_pkt_pid;
      w_data_len_nxt = r_data_len;
    end

    if (w_emit) begin
      w_data_out_nxt = r_d0;
    end else begin
      w_data_out_nxt = r_data_out;
    end

    if (w_tok_done) begin
      w_pkt_addr_nxt  = w_tok_nxt[6:0];
      w_pkt_endp_nxt  = w_tok_nxt[10:7];
      w_pkt_frame_nxt = w_tok_nxt[10:0];
    end else begin
      w_pkt_addr_nxt  = r_pkt_addr;
      w_pkt_endp_nxt  = r_pkt_endp;
      w_pkt_frame_nxt = r_pkt_frame;
    end
  end

  // Output registers.
  always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
    if (!NRST_A_USB) begin
      r_pkt_pid   <= 4'h0;
      r_pkt_addr  <= 7'h00;
      r_pkt_endp  <= 4'h0;
      r_pkt_frame <= 11'h000;
      r_tok_valid <= 1'b0;
      r_hsk_valid <= 1'b0;
      r_data_out  <= 8'h00;
      r_data_strb <= 1'b0;
      r_data_end  <= 1'b0;
      r_data_len  <= '0;
      r_pkt_err   <= 1'b0;
      r_err_code  <= 3'd0;
    end else begin
      r_pkt_pid   <= w_pkt_pid_nxt;
      r_pkt_addr  <= w_pkt_addr_nxt;
      r_pkt_endp  <= w_pkt_endp_nxt;
      r_pkt_frame <= w_pkt_frame_nxt;
      r_tok_valid <= w_tok_valid_nxt;
      r_hsk_valid <= w_hsk_valid_nxt;
      r_data_out  <= w_data_out_nxt;
      r_data_strb <= w_data_strb_nxt;
      r_data_end  <= w_data_end_nxt;
      r_data_len  <= w_data_len_nxt;
      r_pkt_err   <= w_pkt_err_nxt;
      r_err_code  <= w_err_code_nxt;
    end
  end

  assign PKT_PID     = r_pkt_pid;
  assign PKT_ADDR    = r_pkt_addr;
  assign PKT_ENDP    = r_pkt_endp;
  assign PKT_FRAME   = r_pkt_frame;
  assign TOKEN_VALID = r_tok_valid;
  assign HSK_VALID   = r_hsk_valid;
  assign DATA_OUT    = r_data_out;
  assign DATA_STRB   = r_data_strb;
  assign DATA_END    = r_data_end;
  assign DATA_LEN    = r_data_len;
  assign PKT_ERR     = r_pkt_err;
  assign ERR_CODE    = r_err_code;

endmodule

// File: tb/tb_usb_rx_packet.sv
// Scoreboard bench for usb_rx_packet: stimulus pushes expected pulses,
// a negedge monitor pops and compares whenever the DUT pulses.
module tb_usb_rx_packet;

  localparam int MAXP = 1023;
  localparam int K_TOK = 0, K_HSK = 1, K_STRB = 2, K_END = 3, K_ERR = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_strb = 1'b0, rx_end = 1'b0, rx_fail = 1'b0;
  logic [3:0]  pkt_pid, pkt_endp;
  logic [6:0]  pkt_addr;
  logic [10:0] pkt_frame, data_len;
  logic        token_valid, hsk_valid, data_strb, data_end, pkt_err;
  logic [7:0]  data_out;
  logic [2:0]  err_code;

  usb_rx_packet #(.MAX_PAYLOAD(MAXP), .LEN_W(11)) dut (
    .CLK_60M(clk), .NRST_A_USB(rst_n), .RX_DATA(rx_data), .RX_STRB(rx_strb),
    .RX_END(rx_end), .RX_FAIL(rx_fail), .PKT_PID(pkt_pid), .PKT_ADDR(pkt_addr),
    .PKT_ENDP(pkt_endp), .PKT_FRAME(pkt_frame), .TOKEN_VALID(token_valid),
    .HSK_VALID(hsk_valid), .DATA_OUT(data_out), .DATA_STRB(data_strb),
    .DATA_END(data_end), .DATA_LEN(data_len), .PKT_ERR(pkt_err), .ERR_CODE(err_code)
  );

  always #8 clk = ~clk;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int          kind;
    logic [7:0]  data;
    logic [3:0]  pid;
    logic [10:0] frame;
    logic [10:0] len;
    logic [2:0]  code;
  } ev_t;

  ev_t sb[$];
  int errors = 0;
  int checks = 0;
  logic [3:0]  last_pid = 4'h0;
  logic [10:0] last_frame = 11'h000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [7:0] d, input logic [3:0] pid,
                      input logic [10:0] frame, input logic [10:0] len, input logic [2:0] code);
    ev_t e;
    e.kind = kind; e.data = d; e.pid = pid; e.frame = frame; e.len = len; e.code = code;
    sb.push_back(e);
  endtask

  task automatic exp_tok(input logic [3:0] pid, input logic [10:0] frame);
    push(K_TOK, 8'h00, pid, frame, 11'd0, 3'd0);
    last_frame = frame;
  endtask
  task automatic exp_hsk(input logic [3:0] pid); push(K_HSK, 8'h00, pid, 11'd0, 11'd0, 3'd0); endtask
  task automatic exp_strb(input logic [7:0] d);  push(K_STRB, d, 4'h0, 11'd0, 11'd0, 3'd0);    endtask
  task automatic exp_end(input int len);         push(K_END, 8'h00, 4'h0, 11'd0, 11'(len), 3'd0); endtask
  task automatic exp_err(input logic [2:0] c);   push(K_ERR, 8'h00, 4'h0, 11'd0, 11'd0, c);    endtask

  // Pop one expectation and compare it with what the DUT presented.
  task automatic mon(input int k);
    ev_t e;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_pulse: got pulse kind %0d, required none", k);
    end else begin
      e = sb.pop_front();
      chk("pulse_kind", k, e.kind);
      if (e.kind == k) begin
        case (k)
          K_TOK: begin
            chk("tok_pid", pkt_pid, e.pid);
            chk("tok_addr", pkt_addr, e.frame[6:0]);
            chk("tok_endp", pkt_endp, e.frame[10:7]);
            chk("tok_frame", pkt_frame, e.frame);
          end
          K_HSK:   chk("hsk_pid", pkt_pid, e.pid);
          K_STRB:  chk("data_out", data_out, e.data);
          K_END:   chk("data_len", data_len, e.len);
          default: chk("err_code", err_code, e.code);
        endcase
      end
    end
  endtask

  // Monitor: compare every output pulse against the scoreboard, data bytes before packet end.
  always @(negedge clk) begin
    if (rst_n) begin
      if (data_strb)   mon(K_STRB);
      if (token_valid) mon(K_TOK);
      if (hsk_valid)   mon(K_HSK);
      if (data_end)    mon(K_END);
      if (pkt_err)     mon(K_ERR);
    end
  end

  // Reference CRCs straight from the polynomial definitions, bit 0 of each byte first.
  function automatic logic [4:0] crc5_of(input logic [15:0] v, input int nbits);
    logic [4:0] c; logic fb;
    c = 5'h1F;
    for (int i = 0; i < nbits; i++) begin
      fb = c[4] ^ v[i];
      c = {c[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
    end
    return c;
  endfunction

  function automatic logic [15:0] crc16_of(input bq_t b, input int from, input int upto);
    logic [15:0] c; logic fb;
    c = 16'hFFFF;
    for (int k = from; k < upto; k++)
      for (int i = 0; i < 8; i++) begin
        fb = c[15] ^ b[k][i];
        c = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
      end
    return c;
  endfunction

  function automatic bq_t mk_token(input logic [3:0] pid, input logic [10:0] f);
    bq_t q; logic [4:0] c; logic [15:0] w;
    c = crc5_of({5'b0, f}, 11);
    w[10:0] = f;
    for (int i = 0; i < 5; i++) w[11+i] = ~c[4-i];
    q.push_back({~pid, pid}); q.push_back(w[7:0]); q.push_back(w[15:8]);
    return q;
  endfunction

  function automatic bq_t mk_data(input logic [3:0] pid, input int n);
    bq_t q; logic [15:0] c; logic [7:0] b0, b1;
    q.push_back({~pid, pid});
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    c = crc16_of(q, 1, q.size());
    for (int i = 0; i < 8; i++) begin b0[i] = ~c[15-i]; b1[i] = ~c[7-i]; end
    q.push_back(b0); q.push_back(b1);
    return q;
  endfunction

  // Packet-level reference model: expected pulses for a byte stream ended by END or FAIL.
  task automatic model(input bq_t b, input bit fail);
    logic [7:0] p; int n, k; logic [15:0] w;
    p = b[0]; n = b.size() - 1; last_pid = p[3:0];
    if (p[7:4] != ~p[3:0]) exp_err(3'd1);
    else if (p[3:0] inside {4'h1, 4'h9, 4'h5, 4'hD}) begin
      if (n > 2) exp_err(3'd4);
      else if (fail) exp_err(3'd5);
      else if (n < 2) exp_err(3'd6);
      else begin
        w = {b[2], b[1]};
        if (crc5_of(w, 16) == 5'h0C) exp_tok(p[3:0], w[10:0]);
        else exp_err(3'd2);
      end
    end else if (p[3:0] inside {4'h3, 4'hB, 4'h7, 4'hF}) begin
      k = (n > MAXP + 2) ? MAXP + 2 : n;
      for (int i = 0; i < k - 2; i++) exp_strb(b[1+i]);
      if (n > MAXP + 2) exp_err(3'd4);
      else if (fail) exp_err(3'd5);
      else if (n < 2) exp_err(3'd6);
      else if (crc16_of(b, 1, b.size()) == 16'h800D) exp_end(n - 2);
      else exp_err(3'd3);
    end else if (p[3:0] inside {4'h2, 4'hA, 4'hE, 4'h6}) begin
      if (n > 0) exp_err(3'd4);
      else if (fail) exp_err(3'd5);
      else exp_hsk(p[3:0]);
    end else exp_err(3'd4);
  endtask

  // Drive one packet; entered and left just after a rising edge.
  task automatic send(input bq_t b, input bit fail);
    bit same;
    same = !fail && ($urandom_range(0, 2) == 0);
    for (int i = 0; i < b.size(); i++) begin
      if (b.size() < 100 && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
      rx_strb = 1'b1; rx_data = b[i];
      rx_end = same && (i == b.size() - 1);
      @(posedge clk); #1;
      rx_strb = 1'b0; rx_end = 1'b0; rx_data = 8'($urandom);
    end
    if (!same) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      rx_end = !fail; rx_fail = fail;
      @(posedge clk); #1;
      rx_end = 1'b0; rx_fail = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 40) begin @(posedge clk); #1; t++; end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d events pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pid"}, pkt_pid, 0);     chk({tag, "_addr"}, pkt_addr, 0);
    chk({tag, "_endp"}, pkt_endp, 0);   chk({tag, "_frame"}, pkt_frame, 0);
    chk({tag, "_tokv"}, token_valid, 0); chk({tag, "_hskv"}, hsk_valid, 0);
    chk({tag, "_dout"}, data_out, 0);   chk({tag, "_dstrb"}, data_strb, 0);
    chk({tag, "_dend"}, data_end, 0);   chk({tag, "_dlen"}, data_len, 0);
    chk({tag, "_err"}, pkt_err, 0);     chk({tag, "_code"}, err_code, 0);
  endtask

  initial begin
    bq_t v;
    bit  fail;
    logic [7:0] p;
    logic [3:0] pl[4];

    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: SETUP, address 0 endpoint 0
    v = '{8'h2D, 8'h00, 8'h10}; last_pid = 4'hD; exp_tok(4'hD, 11'h000); send(v, 1'b0);
    // 2: empty DATA0
    v = '{8'hC3, 8'h00, 8'h00}; last_pid = 4'h3; exp_end(0); send(v, 1'b0);
    // 3: GET_DESCRIPTOR setup payload, then the same with a corrupted CRC
    v = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
    for (int i = 1; i <= 8; i++) exp_strb(v[i]);
    exp_end(8); send(v, 1'b0);
    v[10] = 8'h95;
    for (int i = 1; i <= 8; i++) exp_strb(v[i]);
    exp_err(3'd3); send(v, 1'b0);
    // 4: ACK, and ACK with a trailing byte
    v = '{8'hD2}; last_pid = 4'h2; exp_hsk(4'h2); send(v, 1'b0);
    v = '{8'hD2, 8'h5A}; exp_err(3'd4); send(v, 1'b0);
    // 5: broken PID then a normal SOF
    v = '{8'h2C, 8'h00, 8'h10}; last_pid = 4'hC; exp_err(3'd1); send(v, 1'b0);
    v = mk_token(4'h5, 11'h5A3); last_pid = 4'h5; exp_tok(4'h5, 11'h5A3); send(v, 1'b0);
    // 6: abort after three data bytes
    v = '{8'h4B, 8'h11, 8'h22, 8'h33}; last_pid = 4'hB; exp_strb(8'h11); exp_err(3'd5); send(v, 1'b1);
    // short packets
    v = '{8'hC3, 8'h77}; model(v, 1'b0); send(v, 1'b0);
    v = '{8'h69, 8'h01}; model(v, 1'b0); send(v, 1'b0);
    drain();

    // reset in the middle of a token
    rx_strb = 1'b1; rx_data = 8'h2D; @(posedge clk); #1;
    rx_data = 8'h00; @(posedge clk); #1;
    rx_strb = 1'b0; @(posedge clk); #1;
    chk("pid_before_reset", pkt_pid, 4'hD);
    rst_n = 1'b0; #2;
    chk_zero("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1; last_pid = 4'h0; last_frame = 11'h000;
    @(posedge clk); #1;

    // largest accepted payload and one byte beyond it
    v = mk_data(4'h7, MAXP); model(v, 1'b0); send(v, 1'b0);
    v = mk_data(4'h3, MAXP + 1); model(v, 1'b0); send(v, 1'b0);
    drain();

    // randomized packet mix
    pl = '{4'h1, 4'h9, 4'h5, 4'hD};
    for (int n = 0; n < 150; n++) begin
      fail = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 7))
        0, 1: begin
          v = mk_token(pl[$urandom_range(0, 3)], 11'($urandom));
          if ($urandom_range(0, 4) == 0) v[$urandom_range(1, 2)] ^= 8'(1 << $urandom_range(0, 7));
          if ($urandom_range(0, 7) == 0) v.push_back(8'($urandom));
          if ($urandom_range(0, 7) == 0) void'(v.pop_back());
        end
        2, 3, 4: begin
          pl[0] = 4'h1;
          v = mk_data(($urandom_range(0, 1) == 0) ? 4'h3 : 4'hB, $urandom_range(0, 20));
          if ($urandom_range(0, 4) == 0) v[$urandom_range(1, v.size() - 1)] ^= 8'(1 << $urandom_range(0, 7));
          if ($urandom_range(0, 9) == 0) while (v.size() > 2) void'(v.pop_back());
        end
        5: begin
          p[3:0] = ($urandom_range(0, 1) == 0) ? 4'hA : 4'hE;
          p[7:4] = ~p[3:0];
          v = '{p};
          if ($urandom_range(0, 3) == 0) v.push_back(8'($urandom));
        end
        6: begin
          p = 8'($urandom);
          if (p[7:4] == ~p[3:0]) p[7] = ~p[7];
          v = '{p, 8'($urandom)};
        end
        default: begin
          p[3:0] = ($urandom_range(0, 1) == 0) ? 4'hC : 4'h4;
          p[7:4] = ~p[3:0];
          v = '{p};
          repeat ($urandom_range(0, 3)) v.push_back(8'($urandom));
        end
      endcase
      model(v, fail);
      send(v, fail);
    end
    drain();

    chk("hold_pid", pkt_pid, last_pid);
    chk("hold_frame", pkt_frame, last_frame);
    chk("hold_addr", pkt_addr, last_frame[6:0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
